// File: rtl/bscan_pkg.sv
// Shared definitions for the BSCAN command bridge.
// Contents:
//   opcode_e      - command opcode carried in word bits [31:30]
//   state_e       - bridge FSM states
//   WRITE_ACK_TAG - tag byte placed at the top of a write acknowledge
//   ERR_TAG       - tag halfword placed at the top of a timeout error response
//   write_ack_word / err_word - response word builders
package bscan_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_ID    = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_REQ,
    ST_WAIT,
    ST_SEND
  } state_e;

  localparam logic [7:0]  WRITE_ACK_TAG = 8'hA5;
  localparam logic [15:0] ERR_TAG       = 16'hDEAD;

  function automatic logic [31:0] write_ack_word(input logic [15:0] addr);
    return {WRITE_ACK_TAG, 8'h00, addr};
  endfunction

  function automatic logic [31:0] err_word(input logic [15:0] addr);
    return {ERR_TAG, addr};
  endfunction

endpackage

// File: rtl/bscan_cmd_bridge.sv
// Command bridge between the JTAG BSCAN transport and the register bus.
// Decodes 32-bit command words (NOP / WRITE / READ / ID), runs each one as a
// single outstanding request/response on the register bus, and returns one
// response word per command.
// Ports:
//   CLK, nRST            - clock, synchronous active-low reset
//   cmd_enq__ENA/_v/RDY  - command words from the BSCAN capture stage
//   rsp_enq__ENA/_v/RDY  - response words back to the BSCAN shift-out stage
//   bus_req/_write/_addr/_wdata, bus_req_rdy - register bus request channel
//   bus_rsp, bus_rdata   - register bus response (single-cycle pulse)
// All outputs are registered.
module bscan_cmd_bridge
  import bscan_pkg::*;
#(
  parameter int          width     = 32,
  parameter int          addrWidth = 16,
  parameter int          timeout   = 255,
  parameter logic [31:0] bridgeId  = 32'h4A54_0001
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 cmd_enq__ENA,
  input  logic [width-1:0]     cmd_enq_v,
  output logic                 cmd_enq__RDY,
  output logic                 rsp_enq__ENA,
  output logic [width-1:0]     rsp_enq_v,
  input  logic                 rsp_enq__RDY,
  output logic                 bus_req,
  output logic                 bus_write,
  output logic [addrWidth-1:0] bus_addr,
  output logic [width-1:0]     bus_wdata,
  input  logic                 bus_req_rdy,
  input  logic                 bus_rsp,
  input  logic [width-1:0]     bus_rdata
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(timeout);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [width-1:0]     wdata_q, wdata_d;
  logic [width-1:0]     rsp_q, rsp_d;
  logic                 cmd_rdy_q, bus_req_q, rsp_ena_q;

  opcode_e     op;
  logic        accept;
  logic [15:0] addr_ext;
  logic        unused_cmd_bits;

  assign op              = opcode_e'(cmd_enq_v[31:30]);
  assign accept          = cmd_enq__ENA & cmd_rdy_q;
  assign unused_cmd_bits = ^cmd_enq_v[29:16];

  // Latched address zero-extended to the 16-bit field used in responses.
  always_comb begin
    addr_ext                = '0;
    addr_ext[addrWidth-1:0] = addr_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    rsp_d   = rsp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_ID: begin
              rsp_d   = bridgeId;
              state_d = ST_SEND;
            end
            OP_READ: begin
              addr_d  = cmd_enq_v[addrWidth-1:0];
              write_d = 1'b0;
              wdata_d = '0;
              cnt_d   = '0;
              state_d = ST_REQ;
            end
            OP_WRITE: begin
              addr_d  = cmd_enq_v[addrWidth-1:0];
              write_d = 1'b1;
              state_d = ST_WDATA;
            end
            default: ;
          endcase
        end
      end
      // Any word accepted here is write data, never a command.
      ST_WDATA: begin
        if (accept) begin
          wdata_d = cmd_enq_v;
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      // A handshake wins over a timeout landing in the same cycle.
      ST_REQ: begin
        if (bus_req_rdy) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rsp_d   = err_word(addr_ext);
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (bus_rsp) begin
          rsp_d   = write_q ? write_ack_word(addr_ext) : bus_rdata;
          state_d = ST_SEND;
        end else if (cnt_q == TIMEOUT_CNT) begin
          rsp_d   = err_word(addr_ext);
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // Response word is cleared on hand-off so rsp_enq_v reads 0 when idle.
      ST_SEND: begin
        if (rsp_enq__RDY) begin
          rsp_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they line up
  // with the state they describe.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      rsp_q     <= '0;
      cmd_rdy_q <= 1'b0;
      bus_req_q <= 1'b0;
      rsp_ena_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      rsp_q     <= rsp_d;
      cmd_rdy_q <= (state_d == ST_IDLE) || (state_d == ST_WDATA);
      bus_req_q <= (state_d == ST_REQ);
      rsp_ena_q <= (state_d == ST_SEND);
    end
  end

  assign cmd_enq__RDY = cmd_rdy_q;
  assign rsp_enq__ENA = rsp_ena_q;
  assign rsp_enq_v    = rsp_q;
  assign bus_req      = bus_req_q;
  assign bus_write    = write_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;

endmodule

// File: tb/tb_bscan_cmd_bridge.sv
// Testbench for bscan_cmd_bridge: stimulus pushes the expected response of
// each command into a queue; a separate monitor pops and compares on every
// response hand-off.
module tb_bscan_cmd_bridge;

  localparam int          TO        = 8;
  localparam logic [31:0] BRIDGE_ID = 32'h4A54_0001;
  localparam int          STUCK     = 99;

  logic        CLK;
  logic        nRST;
  logic        cmd_enq__ENA;
  logic [31:0] cmd_enq_v;
  logic        cmd_enq__RDY;
  logic        rsp_enq__ENA;
  logic [31:0] rsp_enq_v;
  logic        rsp_enq__RDY;
  logic        bus_req;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_req_rdy;
  logic        bus_rsp;
  logic [31:0] bus_rdata;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          hold_low = 1'b0;

  bscan_cmd_bridge #(
    .width    (32),
    .addrWidth(16),
    .timeout  (TO),
    .bridgeId (BRIDGE_ID)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .cmd_enq__ENA(cmd_enq__ENA),
    .cmd_enq_v   (cmd_enq_v),
    .cmd_enq__RDY(cmd_enq__RDY),
    .rsp_enq__ENA(rsp_enq__ENA),
    .rsp_enq_v   (rsp_enq_v),
    .rsp_enq__RDY(rsp_enq__RDY),
    .bus_req     (bus_req),
    .bus_write   (bus_write),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_req_rdy (bus_req_rdy),
    .bus_rsp     (bus_rsp),
    .bus_rdata   (bus_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the response word a command must produce, given how the bench
  // will behave on the bus (delays beyond the timeout mean "never answered").
  function automatic logic [31:0] ref_rsp(input logic [1:0] op, input logic [15:0] addr,
                                          input logic [31:0] rd, input int j, input int k);
    if (op == 2'b11) return BRIDGE_ID;
    if (j > TO || k > TO) return {16'hDEAD, addr};
    if (op == 2'b01) return {8'hA5, 8'h00, addr};
    return rd;
  endfunction

  // Downstream backpressure: random, or forced low by directed tests.
  initial begin
    rsp_enq__RDY = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      rsp_enq__RDY = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every presented response must match the queue head and stay
  // stable until it is taken.
  always @(negedge CLK) begin
    if (rsp_enq__ENA) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got %h expected none", rsp_enq_v);
      end else begin
        if (rsp_enq_v !== exp_q[0]) begin
          errors++;
          $display("FAIL rsp_data got %h expected %h", rsp_enq_v, exp_q[0]);
        end
        if (rsp_enq__RDY) void'(exp_q.pop_front());
      end
    end else if (rsp_enq_v !== 32'h0) begin
      checks++;
      errors++;
      $display("FAIL rsp_idle_zero got %h expected 00000000", rsp_enq_v);
    end
  end

  task automatic drive_word(input logic [31:0] w);
    int n;
    n = 0;
    cmd_enq__ENA = 1'b1;
    cmd_enq_v    = w;
    while (!cmd_enq__RDY && n < 300) begin
      step();
      n++;
    end
    if (!cmd_enq__RDY) begin
      checks++;
      errors++;
      $display("FAIL cmd_accept_wait rdy=%b expected 1", cmd_enq__RDY);
    end
    step();
    cmd_enq__ENA = 1'b0;
    cmd_enq_v    = $urandom;
  endtask

  task automatic late_rsp();
    bus_rsp   = 1'b1;
    bus_rdata = $urandom;
    step();
    bus_rsp   = 1'b0;
  endtask

  // Called in the cycle REQ was entered.
  task automatic run_bus(input int j, input int k, input logic [31:0] rd, input bit dual);
    if (j > TO) begin
      repeat (TO) step();
      chk("req_before_timeout_req", {31'b0, bus_req}, 1);
      chk("req_before_timeout_ena", {31'b0, rsp_enq__ENA}, 0);
      step();
      chk("req_timeout_ena", {31'b0, rsp_enq__ENA}, 1);
      chk("req_timeout_drop", {31'b0, bus_req}, 0);
      late_rsp();
      return;
    end
    repeat (j) step();
    bus_req_rdy = 1'b1;
    if (dual) begin
      bus_rsp   = 1'b1;
      bus_rdata = ~rd;
    end
    step();
    bus_req_rdy = 1'b0;
    bus_rsp     = 1'b0;
    chk("wait_req_low", {31'b0, bus_req}, 0);
    if (k > TO) begin
      repeat (TO) step();
      chk("wait_before_timeout_ena", {31'b0, rsp_enq__ENA}, 0);
      step();
      chk("wait_timeout_ena", {31'b0, rsp_enq__ENA}, 1);
      late_rsp();
      return;
    end
    repeat (k) step();
    bus_rsp   = 1'b1;
    bus_rdata = rd;
    step();
    bus_rsp   = 1'b0;
    chk("rsp_latency", {31'b0, rsp_enq__ENA}, 1);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int j, input int k, input bit dual,
                        input int gap);
    logic [13:0] junk;
    junk = 14'($urandom);
    if (op != 2'b00) exp_q.push_back(ref_rsp(op, addr, rd, j, k));
    drive_word({op, junk, addr});
    case (op)
      2'b00: begin
        chk("nop_rdy", {31'b0, cmd_enq__RDY}, 1);
        chk("nop_no_rsp", {31'b0, rsp_enq__ENA}, 0);
      end
      2'b11: begin
        chk("id_latency", {31'b0, rsp_enq__ENA}, 1);
        chk("id_cmd_rdy_low", {31'b0, cmd_enq__RDY}, 0);
      end
      2'b10: begin
        chk("rd_req", {31'b0, bus_req}, 1);
        chk("rd_write", {31'b0, bus_write}, 0);
        chk("rd_addr", {16'b0, bus_addr}, {16'b0, addr});
        run_bus(j, k, rd, dual);
      end
      default: begin
        chk("wdata_rdy", {31'b0, cmd_enq__RDY}, 1);
        chk("wdata_no_req", {31'b0, bus_req}, 0);
        repeat (gap) step();
        drive_word(wd);
        chk("wr_req", {31'b0, bus_req}, 1);
        chk("wr_write", {31'b0, bus_write}, 1);
        chk("wr_addr", {16'b0, bus_addr}, {16'b0, addr});
        chk("wr_wdata", bus_wdata, wd);
        run_bus(j, k, rd, dual);
      end
    endcase
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 7);
    if (r <= 4) return r;
    if (r == 5) return TO;
    if (r == 6) return STUCK;
    return 1;
  endfunction

  initial begin
    int n;
    nRST         = 1'b0;
    cmd_enq__ENA = 1'b0;
    cmd_enq_v    = '0;
    bus_req_rdy  = 1'b0;
    bus_rsp      = 1'b0;
    bus_rdata    = '0;

    step();
    chk("reset_cmd_rdy", {31'b0, cmd_enq__RDY}, 0);
    chk("reset_rsp_ena", {31'b0, rsp_enq__ENA}, 0);
    chk("reset_bus_req", {31'b0, bus_req}, 0);
    chk("reset_bus_addr", {16'b0, bus_addr}, 0);
    nRST = 1'b1;
    step();
    chk("post_reset_cmd_rdy", {31'b0, cmd_enq__RDY}, 1);

    // Directed cases
    do_cmd(2'b11, 16'h0000, 32'h0, 32'h0, 0, 0, 1'b0, 0);
    do_cmd(2'b10, 16'h0010, 32'h0, 32'h1234_5678, 2, 3, 1'b0, 0);
    do_cmd(2'b01, 16'h0020, 32'hCAFE_F00D, 32'h0, 1, 1, 1'b0, 0);
    do_cmd(2'b10, 16'h0030, 32'h0, 32'h0, STUCK, 0, 1'b0, 0);
    do_cmd(2'b10, 16'h0040, 32'h0, 32'h0BAD_CAFE, 1, 2, 1'b1, 0);
    do_cmd(2'b00, 16'h0050, 32'h0, 32'h0, 0, 0, 1'b0, 0);

    // ID under sustained backpressure
    n = 0;
    while (!cmd_enq__RDY && n < 300) begin step(); n++; end
    hold_low = 1'b1;
    do_cmd(2'b11, 16'h0000, 32'h0, 32'h0, 0, 0, 1'b0, 0);
    repeat (5) begin
      step();
      chk("bp_ena_held", {31'b0, rsp_enq__ENA}, 1);
      chk("bp_data_held", rsp_enq_v, BRIDGE_ID);
      chk("bp_cmd_rdy_low", {31'b0, cmd_enq__RDY}, 0);
    end
    hold_low = 1'b0;

    // Reset while waiting for a bus response: the read must vanish
    drive_word(32'h8000_0044);
    chk("rst_rd_req", {31'b0, bus_req}, 1);
    bus_req_rdy = 1'b1;
    step();
    bus_req_rdy = 1'b0;
    nRST = 1'b0;
    step();
    chk("rst_mid_cmd_rdy", {31'b0, cmd_enq__RDY}, 0);
    chk("rst_mid_rsp_ena", {31'b0, rsp_enq__ENA}, 0);
    chk("rst_mid_bus_req", {31'b0, bus_req}, 0);
    chk("rst_mid_bus_write", {31'b0, bus_write}, 0);
    chk("rst_mid_bus_addr", {16'b0, bus_addr}, 0);
    chk("rst_mid_bus_wdata", bus_wdata, 0);
    nRST    = 1'b1;
    bus_rsp = 1'b1;
    step();
    bus_rsp = 1'b0;
    chk("rst_mid_rdy_back", {31'b0, cmd_enq__RDY}, 1);
    do_cmd(2'b11, 16'h0000, 32'h0, 32'h0, 0, 0, 1'b0, 0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      logic [1:0]  op;
      logic [15:0] addr;
      logic [31:0] wd, rd;
      int          j, k, gap;
      bit          dual;
      op   = 2'($urandom);
      addr = 16'($urandom);
      wd   = $urandom;
      rd   = $urandom;
      j    = pick_delay();
      k    = pick_delay();
      gap  = $urandom_range(0, 3);
      dual = (j <= TO) && ($urandom_range(0, 3) == 0);
      do_cmd(op, addr, wd, rd, j, k, dual, gap);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin step(); n++; end
    step();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bscan_cmd_bridge.md
# bscan_cmd_bridge

Command bridge between the JTAG BSCAN transport and the on-chip register bus. It consumes 32-bit words delivered by the BSCAN capture stage and decodes them as read, write, ID or no-op commands. It executes each command on a single-outstanding request/response register bus and returns one response word per command to the BSCAN stage for shift-out on the next capture.

## Interface
- width, 32, command/response word width; fixed at 32, other values unsupported
- addrWidth, 16, register bus address width, ≤ 16
- timeout, 255, max cycles waited in any bus wait state before error response, 1..255
- bridgeId, 32'h4A54_0001, word returned for the ID command
- CLK  in  1  clock; all logic on posedge
- nRST  in  1  reset, synchronous, active-low
- cmd_enq__ENA  in  1  command word valid (upstream only asserts while cmd_enq__RDY)
- cmd_enq$v  in  width  command word
- cmd_enq__RDY  out  1  bridge can accept a word this cycle
- rsp_enq__ENA  out  1  response word valid
- rsp_enq$v  out  width  response word, 0 when rsp_enq__ENA low
- rsp_enq__RDY  in  1  downstream accepts response this cycle
- bus_req  out  1  bus request valid
- bus_write  out  1  1 = write, 0 = read
- bus_addr  out  addrWidth  bus address
- bus_wdata  out  width  write data
- bus_req_rdy  in  1  bus accepts request this cycle
- bus_rsp  in  1  bus response valid (single cycle)
- bus_rdata  in  width  read data, valid with bus_rsp

## Operation
- Command word: [31:30] opcode (00 NOP, 01 WRITE, 10 READ, 11 ID), [29:16] ignored, [15:0] address (low addrWidth bits used).
- A transfer occurs on a cycle with X__ENA and X__RDY both high.
- States: IDLE, WDATA, REQ, WAIT, SEND.
- IDLE: cmd_enq__RDY=1.
  - NOP → stay IDLE, no response.
  - ID → SEND with bridgeId.
  - READ → latch address, REQ.
  - WRITE → latch address, WDATA.
- WDATA: cmd_enq__RDY=1. The next accepted word is write data → latch, REQ. No decode in WDATA; any word is data.
- REQ: bus_req=1 with stable bus_write/bus_addr/bus_wdata. On bus_req_rdy → WAIT.
- WAIT: on bus_rsp → SEND.
  - READ: response is bus_rdata.
  - WRITE: response is {8'hA5, 8'h00, 16-bit zero-extended address}.
- Timeout: a counter clears on entry to REQ and on entry to WAIT, and increments each cycle in REQ/WAIT. When it reaches timeout without exit → SEND with {16'hDEAD, address}, bus_req dropped.
- bus_rsp outside WAIT is ignored (late response after timeout is discarded).
- SEND: rsp_enq__ENA=1, rsp_enq$v held stable until rsp_enq__RDY, then → IDLE.
- Single command in flight; cmd_enq__RDY=0 in REQ, WAIT, SEND.

## Timing
- Reset values: cmd_enq__RDY=0 during the reset cycle, 1 the cycle after; all other outputs 0; state IDLE; counter 0.
- READ accepted in cycle N → bus_req high at N+1. bus_req_rdy at M → WAIT at M+1. bus_rsp at K → rsp_enq__ENA at K+1.
- ID accepted at N → rsp_enq__ENA at N+1.
- WRITE accepted at N, data word at N+d → bus_req at N+d+1.
- bus_req_rdy and bus_rsp in the same cycle while in REQ: bus_rsp ignored; the response must come later.
- Timeout fires on the cycle the counter equals timeout: REQ or WAIT entered at T → SEND at T+timeout+1.
- nRST low in any state: next cycle IDLE, all outputs 0, latched command discarded, no response for it.

## Structure
- Shared package bscan_pkg: opcode enum (NOP/WRITE/READ/ID), state enum, constants WRITE_ACK_TAG=8'hA5, ERR_TAG=16'hDEAD.
- Single module. No sub-module; counter and FSM inline.
- Instantiated downstream of the BSCAN stage's fromBscan pipe, with rsp_enq feeding its toBscan pipe.

## Test plan
- ID: cmd 32'hC000_0000 → one cycle later rsp_enq$v=32'h4A54_0001, held until rsp_enq__RDY.
- Read: cmd 32'h8000_0010; bus model gives req_rdy after 2 cycles and rsp with 32'h1234_5678 3 cycles later → bus_addr=16'h0010, bus_write=0; response 32'h1234_5678.
- Write: cmd 32'h4000_0020 then 32'hCAFE_F00D → bus_write=1, bus_addr=16'h0020, bus_wdata=32'hCAFE_F00D; response 32'hA500_0020.
- Timeout: read 16'h0030 with bus_req_rdy stuck low, timeout=8 → SEND 9 cycles after REQ entry; response 32'hDEAD_0030; later bus_rsp ignored.
- NOP plus backpressure: NOP → no response, RDY stays 1. ID with rsp_enq__RDY low for 5 cycles → ENA and data stable, cmd_enq__RDY=0 until accepted.
- Reset mid-op: nRST low while in WAIT → next cycle all outputs 0. Subsequent ID returns bridgeId normally.
